// File: rtl/regfile_wb.sv
// ---------------------------------------------------------------------------
// regfile_wb -- 8 x 8-bit register file with a buffered writeback port.
//
// ALU results arrive over a valid/ready handshake into a 2-entry circular
// write queue. The queue drains one entry per cycle into the register array
// unless wr_hold stalls it. Both combinational read ports forward the
// youngest matching queued entry, so a read never returns a stale value.
// Read port 2 (w_rd2) is the operand that the ALU source-B select chooses
// between, alongside the immediate constant.
//
// Optional feature (macro REGFILE_ZERO_REG_EN):
//   defined   -> register 0 reads as 0. Writebacks to address 0 complete the
//                handshake normally but are dropped before entering the queue.
//   undefined -> register 0 is an ordinary register.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   wb_valid      in   writeback request present
//   wb_ready      out  queue can accept (pending != 2)
//   wb_addr       in   [ADDR_W] destination register
//   wb_data       in   [DATA_W] value to write
//   wr_hold       in   stalls draining of the queue into the array
//   ra1, ra2      in   [ADDR_W] read addresses
//   w_rd1, w_rd2  out  [DATA_W] combinational read data (with forwarding)
//   commit_valid  out  registered pulse: an entry was written to the array
//   commit_addr   out  [ADDR_W] address of the last commit (holds otherwise)
//   pending       out  [2] number of queued entries (0..2)
// ---------------------------------------------------------------------------
module regfile_wb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int QDEPTH = 2   // only 2 is supported: pointers are 1 bit wide
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wr_hold,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] w_rd1,
  output logic [DATA_W-1:0] w_rd2,
  output logic              commit_valid,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [1:0]        pending
);

  localparam int         DEPTH  = 2 ** ADDR_W;
  localparam logic [1:0] Q_FULL = 2'(QDEPTH);

  // Register array, kept in flops so that reset clears every entry.
  logic [DATA_W-1:0] r_regs [DEPTH];

  // Write queue storage and control.
  logic [ADDR_W-1:0] r_q_addr [QDEPTH];
  logic [DATA_W-1:0] r_q_data [QDEPTH];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              r_commit_valid;
  logic [ADDR_W-1:0] r_commit_addr;

  logic              w_full;
  logic              w_accept;
  logic              w_enq;
  logic              w_drain;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_young;
  logic [DATA_W-1:0] w_rd1_c;
  logic [DATA_W-1:0] w_rd2_c;

  // ---------------------------------------------------------------------
  // Handshake and queue control
  // ---------------------------------------------------------------------
  // Readiness depends only on the current count: a full queue refuses even
  // when it drains in the same cycle (no pass-through).
  assign w_full   = (r_count == Q_FULL);
  assign wb_ready = !w_full;
  assign w_accept = wb_valid && !w_full;

`ifdef REGFILE_ZERO_REG_EN
  // Writes to the hardwired zero register finish the handshake but are
  // never stored, so they neither occupy the queue nor commit.
  assign w_enq = w_accept && (wb_addr != '0);
`else
  assign w_enq = w_accept;
`endif

  assign w_drain     = (r_count != 2'd0) && !wr_hold;
  assign w_head_addr = r_q_addr[r_rd_ptr];
  assign w_head_data = r_q_data[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_addr[i] <= '0;
        r_q_data[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_q_addr[r_wr_ptr] <= wb_addr;
        r_q_data[r_wr_ptr] <= wb_data;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_drain) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Enqueue together with drain leaves the count unchanged.
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Register array write (drain of the queue head)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_drain) begin
      r_regs[w_head_addr] <= w_head_data;
    end
  end

  // Commit report: a one-cycle pulse; the address keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_valid <= 1'b0;
      r_commit_addr  <= '0;
    end else begin
      r_commit_valid <= w_drain;
      if (w_drain) begin
        r_commit_addr <= w_head_addr;
      end
    end
  end

  assign commit_valid = r_commit_valid;
  assign commit_addr  = r_commit_addr;
  assign pending      = r_count;

  // ---------------------------------------------------------------------
  // Read ports with forwarding
  // ---------------------------------------------------------------------
  // The most recently written slot is always the one just behind the write
  // pointer. With one entry queued it coincides with the head, with two it
  // is the slot after the head. The head (older) is checked first so that
  // the younger match overrides it.
  assign w_young = ~r_wr_ptr;

  always_comb begin
    w_rd1_c = r_regs[ra1];
    if ((r_count != 2'd0) && (r_q_addr[r_rd_ptr] == ra1)) begin
      w_rd1_c = r_q_data[r_rd_ptr];
    end
    if ((r_count != 2'd0) && (r_q_addr[w_young] == ra1)) begin
      w_rd1_c = r_q_data[w_young];
    end
`ifdef REGFILE_ZERO_REG_EN
    if (ra1 == '0) begin
      w_rd1_c = '0;
    end
`endif
  end

  always_comb begin
    w_rd2_c = r_regs[ra2];
    if ((r_count != 2'd0) && (r_q_addr[r_rd_ptr] == ra2)) begin
      w_rd2_c = r_q_data[r_rd_ptr];
    end
    if ((r_count != 2'd0) && (r_q_addr[w_young] == ra2)) begin
      w_rd2_c = r_q_data[w_young];
    end
`ifdef REGFILE_ZERO_REG_EN
    if (ra2 == '0) begin
      w_rd2_c = '0;
    end
`endif
  end

  assign w_rd1 = w_rd1_c;
  assign w_rd2 = w_rd2_c;

endmodule

// File: tb/tb_regfile_wb.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb -- self-checking bench for regfile_wb.
// Table of hand-derived vectors, hand-written multi-cycle sequences
// (simultaneous enqueue/drain, reset with a full queue) and a randomized
// phase checked against a queue/array reference model.
// ---------------------------------------------------------------------------
module tb_regfile_wb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wb_valid;
  logic       wb_ready;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       wr_hold;
  logic [2:0] ra1;
  logic [2:0] ra2;
  logic [7:0] w_rd1;
  logic [7:0] w_rd2;
  logic       commit_valid;
  logic [2:0] commit_addr;
  logic [1:0] pending;

  always #5 clk = ~clk;

  regfile_wb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wr_hold      (wr_hold),
    .ra1          (ra1),
    .ra2          (ra2),
    .w_rd1        (w_rd1),
    .w_rd2        (w_rd2),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr),
    .pending      (pending)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [2:0] a;
    logic [7:0] d;
    logic       h;
    logic [2:0] r1;
    logic [2:0] r2;
    logic       rdy;
    logic [1:0] pend;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic       cv;
    logic [2:0] ca;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [2:0] a, input logic [7:0] d,
                              input logic h, input logic [2:0] r1, input logic [2:0] r2,
                              input logic rdy, input logic [1:0] pend, input logic [7:0] rd1,
                              input logic [7:0] rd2, input logic cv, input logic [2:0] ca);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.h = h; t.r1 = r1; t.r2 = r2;
    t.rdy = rdy; t.pend = pend; t.rd1 = rd1; t.rd2 = rd2; t.cv = cv; t.ca = ca;
    return t;
  endfunction

  vec_t tbl [18];

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] marr [8];
  logic       mcv;
  logic [2:0] mca;

  function automatic logic [7:0] mread(input logic [2:0] ra);
`ifdef REGFILE_ZERO_REG_EN
    if (ra == 3'd0) return 8'h00;
`endif
    for (int k = mq.size() - 1; k >= 0; k--)
      if (mq[k].a == ra) return mq[k].d;
    return marr[ra];
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < 8; k++) marr[k] = 8'h00;
    mcv = 1'b0;
    mca = 3'd0;
  endtask

  task automatic model_step();
    ent_t e;
    logic acc;
    acc = wb_valid && (mq.size() < 2);
    if (mq.size() > 0 && !wr_hold) begin
      e = mq.pop_front();
      marr[e.a] = e.d;
      mcv = 1'b1;
      mca = e.a;
    end else begin
      mcv = 1'b0;
    end
    if (acc) begin
      e.a = wb_addr;
      e.d = wb_data;
`ifdef REGFILE_ZERO_REG_EN
      if (wb_addr != 3'd0) mq.push_back(e);
`else
      mq.push_back(e);
`endif
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] a, input logic [7:0] d,
                       input logic h, input logic [2:0] r1, input logic [2:0] r2);
    wb_valid = v; wb_addr = a; wb_data = d; wr_hold = h; ra1 = r1; ra2 = r2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    tbl[0]  = mk(1'b1, 3'd2, 8'h3C, 1'b0, 3'd2, 3'd2,  1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 3'd0);
    tbl[1]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2,  1'b1, 2'd1, 8'h00, 8'h3C, 1'b0, 3'd0);
    tbl[2]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 3'd2,  1'b1, 2'd0, 8'h3C, 8'h3C, 1'b1, 3'd2);
    tbl[3]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd2,  1'b1, 2'd0, 8'h00, 8'h3C, 1'b0, 3'd2);
    tbl[4]  = mk(1'b1, 3'd1, 8'h11, 1'b1, 3'd1, 3'd5,  1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 3'd2);
    tbl[5]  = mk(1'b1, 3'd5, 8'h55, 1'b1, 3'd1, 3'd5,  1'b1, 2'd1, 8'h11, 8'h00, 1'b0, 3'd2);
    tbl[6]  = mk(1'b1, 3'd6, 8'h66, 1'b1, 3'd1, 3'd5,  1'b0, 2'd2, 8'h11, 8'h55, 1'b0, 3'd2);
    tbl[7]  = mk(1'b1, 3'd6, 8'h66, 1'b0, 3'd6, 3'd5,  1'b0, 2'd2, 8'h00, 8'h55, 1'b0, 3'd2);
    tbl[8]  = mk(1'b1, 3'd6, 8'h66, 1'b0, 3'd1, 3'd6,  1'b1, 2'd1, 8'h11, 8'h00, 1'b1, 3'd1);
    tbl[9]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd6,  1'b1, 2'd1, 8'h55, 8'h66, 1'b1, 3'd5);
    tbl[10] = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd6, 3'd2,  1'b1, 2'd0, 8'h66, 8'h3C, 1'b1, 3'd6);
    tbl[11] = mk(1'b1, 3'd7, 8'h10, 1'b1, 3'd7, 3'd7,  1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 3'd6);
    tbl[12] = mk(1'b1, 3'd7, 8'h20, 1'b1, 3'd7, 3'd7,  1'b1, 2'd1, 8'h10, 8'h10, 1'b0, 3'd6);
    tbl[13] = mk(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 3'd3,  1'b0, 2'd2, 8'h20, 8'h00, 1'b0, 3'd6);
    tbl[14] = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 3'd7,  1'b0, 2'd2, 8'h20, 8'h20, 1'b0, 3'd6);
    tbl[15] = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 3'd7,  1'b1, 2'd1, 8'h20, 8'h20, 1'b1, 3'd7);
    tbl[16] = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 3'd1,  1'b1, 2'd0, 8'h20, 8'h11, 1'b1, 3'd7);
    tbl[17] = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 3'd5,  1'b1, 2'd0, 8'h20, 8'h55, 1'b0, 3'd7);

    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // Reset state
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_ready", 32'(wb_ready), 32'd1);
    chk("reset_commit_valid", 32'(commit_valid), 32'd0);
    chk("reset_commit_addr", 32'(commit_addr), 32'd0);
    chk("reset_rd1", 32'(w_rd1), 32'd0);
    chk("reset_rd2", 32'(w_rd2), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].r1, tbl[i].r2);
      @(negedge clk);
      $display("vec %0d: v=%0d a=%0d d=0x%02h hold=%0d ra1=%0d ra2=%0d -> rdy=%0d pend=%0d rd1=0x%02h rd2=0x%02h cv=%0d ca=%0d",
               i, wb_valid, wb_addr, wb_data, wr_hold, ra1, ra2,
               wb_ready, pending, w_rd1, w_rd2, commit_valid, commit_addr);
      chk($sformatf("vec%0d_ready", i), 32'(wb_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
      chk($sformatf("vec%0d_rd1", i), 32'(w_rd1), 32'(tbl[i].rd1));
      chk($sformatf("vec%0d_rd2", i), 32'(w_rd2), 32'(tbl[i].rd2));
      chk($sformatf("vec%0d_commit_valid", i), 32'(commit_valid), 32'(tbl[i].cv));
      chk($sformatf("vec%0d_commit_addr", i), 32'(commit_addr), 32'(tbl[i].ca));
      next_cycle();
    end

    // Simultaneous enqueue and drain (second write targets address 0)
    drive(1'b1, 3'd4, 8'h44, 1'b0, 3'd4, 3'd4);
    @(negedge clk);
    chk("sim_pre_pending", 32'(pending), 32'd0);
    next_cycle();
    drive(1'b1, 3'd0, 8'h99, 1'b0, 3'd0, 3'd4);
    @(negedge clk);
    chk("sim_pending_one", 32'(pending), 32'd1);
    chk("sim_ready", 32'(wb_ready), 32'd1);
    chk("sim_fwd_rd2", 32'(w_rd2), 32'h44);
    next_cycle();
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd4);
    @(negedge clk);
    $display("sim enq+drain: pend=%0d cv=%0d ca=%0d rd1=0x%02h", pending, commit_valid, commit_addr, w_rd1);
    chk("sim_commit_valid", 32'(commit_valid), 32'd1);
    chk("sim_commit_addr", 32'(commit_addr), 32'd4);
    chk("sim_rd2_array", 32'(w_rd2), 32'h44);
`ifdef REGFILE_ZERO_REG_EN
    chk("sim_pending_after", 32'(pending), 32'd0);
    chk("sim_rd1_zero", 32'(w_rd1), 32'h00);
`else
    chk("sim_pending_after", 32'(pending), 32'd1);
    chk("sim_rd1_fwd", 32'(w_rd1), 32'h99);
`endif
    next_cycle();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4);
    next_cycle();
    @(negedge clk);
    chk("sim_final_pending", 32'(pending), 32'd0);
`ifdef REGFILE_ZERO_REG_EN
    chk("sim_final_cv", 32'(commit_valid), 32'd0);
    chk("sim_final_ca", 32'(commit_addr), 32'd4);
    chk("sim_final_rd1", 32'(w_rd1), 32'h00);
`else
    chk("sim_final_cv", 32'(commit_valid), 32'd1);
    chk("sim_final_ca", 32'(commit_addr), 32'd0);
    chk("sim_final_rd1", 32'(w_rd1), 32'h99);
`endif
    next_cycle();

    // Reset with a full, held queue
    drive(1'b1, 3'd3, 8'h5A, 1'b1, 3'd3, 3'd4);
    next_cycle();
    drive(1'b1, 3'd4, 8'hA5, 1'b1, 3'd3, 3'd4);
    next_cycle();
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd4);
    @(negedge clk);
    chk("rstq_pending_full", 32'(pending), 32'd2);
    chk("rstq_fwd_rd1", 32'(w_rd1), 32'h5A);
    chk("rstq_fwd_rd2", 32'(w_rd2), 32'hA5);
    rst_n = 1'b0;
    #1;
    $display("reset mid-queue: pend=%0d rdy=%0d cv=%0d rd1=0x%02h", pending, wb_ready, commit_valid, w_rd1);
    chk("rstq_pending", 32'(pending), 32'd0);
    chk("rstq_ready", 32'(wb_ready), 32'd1);
    chk("rstq_commit_valid", 32'(commit_valid), 32'd0);
    chk("rstq_commit_addr", 32'(commit_addr), 32'd0);
    chk("rstq_rd1", 32'(w_rd1), 32'h00);
    chk("rstq_rd2", 32'(w_rd2), 32'h00);
    ra1 = 3'd2;
    ra2 = 3'd1;
    #1;
    chk("rstq_array_rd1", 32'(w_rd1), 32'h00);
    chk("rstq_array_rd2", 32'(w_rd2), 32'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
    next_cycle();
    model_reset();

    // Randomized phase against the reference model
    for (int i = 0; i < 300; i++) begin
      logic       h;
      logic [7:0] e1;
      logic [7:0] e2;
      if ((i % 40) < 12) h = ($urandom_range(0, 4) != 0);
      else               h = ($urandom_range(0, 3) == 0);
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
            h, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      @(negedge clk);
      e1 = mread(ra1);
      e2 = mread(ra2);
      chk($sformatf("rnd%0d_ready", i), 32'(wb_ready), 32'(mq.size() < 2));
      chk($sformatf("rnd%0d_pending", i), 32'(pending), 32'(mq.size()));
      chk($sformatf("rnd%0d_rd1", i), 32'(w_rd1), 32'(e1));
      chk($sformatf("rnd%0d_rd2", i), 32'(w_rd2), 32'(e2));
      chk($sformatf("rnd%0d_commit_valid", i), 32'(commit_valid), 32'(mcv));
      chk($sformatf("rnd%0d_commit_addr", i), 32'(commit_addr), 32'(mca));
      if (wb_valid && wb_ready)
        $display("rnd %0d: accept addr=%0d data=0x%02h hold=%0d pend=%0d", i, wb_addr, wb_data, wr_hold, pending);
      model_step();
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
